// File: rtl/pin_period_meter_pkg.sv
// Shared types and default constants for the pin period meter.
// Defaults target a 50 MHz sclk; the timeout is three seconds of clock.
package pin_meter_pkg;

    localparam int SCLK_HZ      = 50_000_000;
    localparam int DEF_CNT_W    = 28;
    localparam int DEF_FILT_CYC = 4;
    localparam int DEF_TIMEOUT  = 3 * SCLK_HZ;

    // Filter counter width covers the legal FILT_CYC range of 1..15.
    localparam int FILT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_TOUT = 2'd2
    } meter_state_e;

endpackage

// File: rtl/pin_period_meter_if.sv
// Measurement result bundle: the meter drives it, status/UART logic consumes it.
// There is no back-pressure; a consumer captures period_cnt/high_cnt on period_vld.
interface pin_period_meter_if #(
    parameter int CNT_W = 28
);
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             period_vld;
    logic             timeout;

    modport master (
        output period_cnt,
        output high_cnt,
        output period_vld,
        output timeout
    );

    modport slave (
        input period_cnt,
        input high_cnt,
        input period_vld,
        input timeout
    );
endinterface

// File: rtl/pin_sync_filter.sv
// Two-flop synchroniser plus stability filter for an asynchronous pin.
// The filtered level changes only after FILT_CYC consecutive differing samples.
module pin_sync_filter
    import pin_meter_pkg::*;
#(
    parameter int FILT_CYC = DEF_FILT_CYC
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic io_pin,
    output logic filt_lvl,
    output logic rise,
    output logic fall
);

    logic              sync_p0;
    logic              sync_p1;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_q;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            filt_cnt <= '0;
            filt_lvl <= 1'b0;
            filt_q   <= 1'b0;
        end else begin
            sync_p0 <= io_pin;
            sync_p1 <= sync_p0;
            filt_q  <= filt_lvl;
            // The sample that brings the run length to FILT_CYC commits the new level.
            if (sync_p1 != filt_lvl) begin
                if (filt_cnt == FILT_W'(FILT_CYC - 1)) begin
                    filt_lvl <= sync_p1;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FILT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign rise = filt_lvl & ~filt_q;
    assign fall = ~filt_lvl & filt_q;

endmodule

// File: rtl/pin_period_meter.sv
// Measures period and high time of a filtered pin in sclk cycles, strobing each
// completed period and flagging loss of signal until the next rising edge.
module pin_period_meter
    import pin_meter_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int FILT_CYC = DEF_FILT_CYC,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic               io_pin,
    pin_period_meter_if.master meas
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MEAS = ST_MEAS;
    localparam logic [1:0] S_TOUT = ST_TOUT;

    logic             filt_lvl;
    logic             rise;
    logic             fall;
    logic             meas_rise;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_lat;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             vld_q;
    logic             tout_q;

    pin_sync_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_filt (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .io_pin   (io_pin),
        .filt_lvl (filt_lvl),
        .rise     (rise),
        .fall     (fall)
    );

    assign meas_rise = rise & filt_lvl;
    assign cnt_inc   = cnt + CNT_W'(1);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            high_lat <= '0;
            period_q <= '0;
            high_q   <= '0;
            vld_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (meas_rise) begin
                        state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (fall) begin
                        high_lat <= cnt_inc;
                    end
                    // A rise on the last allowed cycle wins over the timeout.
                    if (meas_rise) begin
                        period_q <= cnt_inc;
                        high_q   <= high_lat;
                        vld_q    <= 1'b1;
                        cnt      <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state  <= S_TOUT;
                        tout_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_TOUT: begin
                    // Counter stays frozen; the next rise restarts without a strobe.
                    if (meas_rise) begin
                        state  <= S_MEAS;
                        cnt    <= '0;
                        tout_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign meas.period_cnt = period_q;
    assign meas.high_cnt   = high_q;
    assign meas.period_vld = vld_q;
    assign meas.timeout    = tout_q;

endmodule

// File: tb/tb_pin_period_meter.sv
// Directed bench for pin_period_meter: table of steady waveforms plus
// hand-written glitch, timeout and mid-measurement reset sequences.
module tb_pin_period_meter;

    localparam int CNT_W    = 16;
    localparam int FILT_CYC = 3;
    localparam int TIMEOUT  = 1000;
    // Pin change just after edge c is first sampled at c+1; the strobe is
    // registered FILT_CYC + 2 edges later, so it is visible at cycle c + 6.
    localparam int LAT = FILT_CYC + 3;

    typedef struct {
        int hi;
        int lo;
        int nper;
        int exp_per;
        int exp_hi;
    } vec_t;

    typedef struct {
        int cyc;
        int per;
        int hi;
    } strobe_t;

    logic sclk;
    logic s_rst_n;
    logic io_pin;
    int   cyc;
    int   nchk;
    int   nerr;
    int   tout_events;
    int   tout_rise_cyc;
    int   tout_fall_cyc;
    logic tout_prev;

    strobe_t sq[$];
    int      rq[$];
    vec_t    vt[4];

    pin_period_meter_if #(.CNT_W(CNT_W)) mif ();

    pin_period_meter #(
        .CNT_W    (CNT_W),
        .FILT_CYC (FILT_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .io_pin  (io_pin),
        .meas    (mif.master)
    );

    initial sclk = 1'b0;
    always #10 sclk = ~sclk;

    initial cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    initial begin
        tout_events   = 0;
        tout_rise_cyc = 0;
        tout_fall_cyc = 0;
        tout_prev     = 1'b0;
    end

    always @(negedge sclk) begin
        strobe_t s;
        if (mif.period_vld) begin
            s.cyc = cyc;
            s.per = int'(mif.period_cnt);
            s.hi  = int'(mif.high_cnt);
            sq.push_back(s);
        end
        if (mif.timeout && !tout_prev) begin
            tout_events   = tout_events + 1;
            tout_rise_cyc = cyc;
        end
        if (!mif.timeout && tout_prev) begin
            tout_fall_cyc = cyc;
        end
        tout_prev = mif.timeout;
    end

    task automatic check(input string name, input int act, input int exp);
        nchk = nchk + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a rising edge; holds the level for n cycles.
    task automatic drive(input logic level, input int n);
        io_pin = level;
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic drive_period(input int hi, input int lo);
        rq.push_back(cyc);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " period_cnt"}, int'(mif.period_cnt), 0);
        check({tag, " high_cnt"}, int'(mif.high_cnt), 0);
        check({tag, " period_vld"}, int'(mif.period_vld), 0);
        check({tag, " timeout"}, int'(mif.timeout), 0);
    endtask

    initial begin
        int base;
        int exp_n;
        int t0;
        int n_before;

        nchk    = 0;
        nerr    = 0;
        s_rst_n = 1'b0;
        io_pin  = 1'b0;

        vt[0] = '{hi: 100, lo: 150, nper: 5, exp_per: 250,  exp_hi: 100};
        vt[1] = '{hi: 40,  lo: 60,  nper: 3, exp_per: 100,  exp_hi: 40};
        vt[2] = '{hi: 3,   lo: 5,   nper: 4, exp_per: 8,    exp_hi: 3};
        vt[3] = '{hi: 500, lo: 500, nper: 2, exp_per: 1000, exp_hi: 500};

        // Reset held with the pin toggling
        repeat (5) begin
            #20 io_pin = ~io_pin;
        end
        check_outputs_zero("reset");
        io_pin = 1'b0;
        @(negedge sclk);
        s_rst_n = 1'b1;
        @(posedge sclk);
        #1;
        drive(1'b0, 10);

        // Table of steady waveforms
        for (int v = 0; v < 4; v++) begin
            sq.delete();
            rq.delete();
            t0 = tout_events;
            for (int p = 0; p <= vt[v].nper; p++) begin
                drive_period(vt[v].hi, vt[v].lo);
            end
            exp_n = (v == 0) ? vt[v].nper : vt[v].nper + 1;
            check($sformatf("vec%0d strobe count", v), sq.size(), exp_n);
            check($sformatf("vec%0d timeout events", v), tout_events - t0, 0);
            if (sq.size() >= vt[v].nper) begin
                base = sq.size() - vt[v].nper;
                for (int k = 0; k < vt[v].nper; k++) begin
                    check($sformatf("vec%0d[%0d] period_cnt", v, k), sq[base+k].per, vt[v].exp_per);
                    check($sformatf("vec%0d[%0d] high_cnt", v, k), sq[base+k].hi, vt[v].exp_hi);
                    check($sformatf("vec%0d[%0d] strobe latency", v, k), sq[base+k].cyc - rq[k+1], LAT);
                end
            end
        end

        // Glitches shorter than FILT_CYC in both phases
        sq.delete();
        rq.delete();
        for (int p = 0; p < 4; p++) begin
            rq.push_back(cyc);
            drive(1'b1, 49);
            drive(1'b0, 2);
            drive(1'b1, 49);
            drive(1'b0, 74);
            drive(1'b1, 2);
            drive(1'b0, 74);
        end
        check("glitch strobe count", sq.size(), 4);
        if (sq.size() == 4) begin
            for (int k = 1; k < 4; k++) begin
                check($sformatf("glitch[%0d] period_cnt", k), sq[k].per, 250);
                check($sformatf("glitch[%0d] high_cnt", k), sq[k].hi, 100);
                check($sformatf("glitch[%0d] latency", k), sq[k].cyc - rq[k], LAT);
            end
        end

        // Loss of signal after a rise
        sq.delete();
        t0 = tout_events;
        drive_period(100, 1200);
        check("timeout events", tout_events - t0, 1);
        check("timeout level", int'(mif.timeout), 1);
        check("timeout strobe count", sq.size(), 1);
        if (sq.size() == 1) begin
            check("timeout delay after rise", tout_rise_cyc - sq[0].cyc, TIMEOUT);
        end
        check("period_cnt held in timeout", int'(mif.period_cnt), 250);
        rq.delete();
        drive_period(100, 150);
        check("timeout cleared", int'(mif.timeout), 0);
        check("timeout clear latency", tout_fall_cyc - rq[0], LAT);
        check("no strobe on restart", sq.size(), 1);
        drive_period(100, 150);
        check("post-timeout strobe count", sq.size(), 2);
        if (sq.size() == 2) begin
            check("post-timeout period_cnt", sq[1].per, 250);
            check("post-timeout high_cnt", sq[1].hi, 100);
        end

        // Single-cycle reset 60 cycles into a high phase
        drive(1'b1, 60);
        @(negedge sclk);
        s_rst_n = 1'b0;
        #1;
        check_outputs_zero("async reset");
        io_pin = 1'b0;
        @(negedge sclk);
        s_rst_n = 1'b1;
        @(posedge sclk);
        #1;
        drive(1'b0, 20);
        check("period_cnt after reset", int'(mif.period_cnt), 0);
        sq.delete();
        n_before = tout_events;
        for (int p = 0; p < 3; p++) begin
            drive_period(100, 150);
        end
        check("post-reset strobe count", sq.size(), 2);
        check("post-reset timeout events", tout_events - n_before, 0);
        if (sq.size() == 2) begin
            check("post-reset period_cnt", sq[0].per, 250);
            check("post-reset high_cnt", sq[0].hi, 100);
            check("post-reset spacing", sq[1].cyc - sq[0].cyc, 250);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
